// File: rtl/ppm_frame_ctrl.sv
// 4-PPM receive sequencer: arms on SOF, samples Din once per slot, decodes symbols into MSB-first bytes.
// Strobes are registered one cycle after the symbol's last cycle; the line cannot be stalled.
module ppm_frame_ctrl #(
    parameter int SLOT_CYCLES  = 16,
    parameter int SAMPLE_POINT = 8,
    parameter int MAX_BYTES    = 16,
    parameter int LEN_W        = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk16,
    input  logic             rst,
    input  logic             en,
    input  logic             Din,
    input  logic             sof_rcv,
    output logic [7:0]       data_out,
    output logic             data_valid,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             busy
);
    localparam int CYC_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(SLOT_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_SAMPLE = CYC_W'(SAMPLE_POINT);
    localparam logic [LEN_W-1:0] BYTES_MAX  = LEN_W'(MAX_BYTES);

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state, state_nxt;
    logic [CYC_W-1:0] cyc_cnt;
    logic [1:0]       slot, sym, sym_val, ev_code;
    logic [LEN_W-1:0] byte_cnt;
    logic [3:0]       pulse_flag, flags_eff;
    logic [7:0]       shifter, sym_byte;
    logic             sample_now, sym_end, ev_valid, ev_done, ev_err;

    // The sample taken on the evaluation cycle itself must count toward that symbol.
    always_comb begin
        sample_now = (cyc_cnt == CYC_SAMPLE);
        sym_end    = (slot == 2'd3) && (cyc_cnt == CYC_LAST);
        flags_eff  = pulse_flag;
        if (sample_now) flags_eff[slot] = ~Din;
        case (flags_eff)
            4'b0010: sym_val = 2'd1;
            4'b0100: sym_val = 2'd2;
            4'b1000: sym_val = 2'd3;
            default: sym_val = 2'd0;
        endcase
    end

    assign sym_byte = {shifter[5:0], sym_val};
    assign busy     = (state == RECV);

    always_comb begin
        state_nxt = state;
        ev_valid  = 1'b0;
        ev_done   = 1'b0;
        ev_err    = 1'b0;
        ev_code   = 2'd0;
        case (state)
            IDLE: if (en && sof_rcv) state_nxt = RECV;
            RECV: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (sym_end) begin
                    if ($onehot(flags_eff)) begin
                        if (byte_cnt == BYTES_MAX) begin
                            ev_err    = 1'b1;
                            ev_code   = 2'd3;
                            state_nxt = IDLE;
                        end else if (sym == 2'd3) begin
                            ev_valid = 1'b1;
                        end
                    end else if (flags_eff == 4'b0000) begin
                        state_nxt = IDLE;
                        if (sym == 2'd0 && byte_cnt != '0) begin
                            ev_done = 1'b1;
                        end else begin
                            ev_err  = 1'b1;
                            ev_code = 2'd1;
                        end
                    end else begin
                        ev_err    = 1'b1;
                        ev_code   = 2'd2;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk16 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk16 or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            err        <= 1'b0;
            err_code   <= '0;
            cyc_cnt    <= '0;
            slot       <= '0;
            sym        <= '0;
            byte_cnt   <= '0;
            pulse_flag <= '0;
            shifter    <= '0;
        end else begin
            data_valid <= ev_valid;
            frame_done <= ev_done;
            err        <= ev_err;
            if (ev_valid) data_out  <= sym_byte;
            if (ev_done)  frame_len <= byte_cnt;
            if (ev_err)   err_code  <= ev_code;
            // Counters sit at zero outside RECV so the entry cycle starts clean.
            if (state != RECV) begin
                cyc_cnt    <= '0;
                slot       <= '0;
                sym        <= '0;
                byte_cnt   <= '0;
                pulse_flag <= '0;
                shifter    <= '0;
            end else begin
                cyc_cnt <= (cyc_cnt == CYC_LAST) ? '0 : cyc_cnt + 1'b1;
                if (cyc_cnt == CYC_LAST) slot <= slot + 2'd1;
                if (sym_end) begin
                    sym        <= sym + 2'd1;
                    pulse_flag <= '0;
                    shifter    <= sym_byte;
                    if (ev_valid) byte_cnt <= byte_cnt + 1'b1;
                end else if (sample_now) begin
                    pulse_flag[slot] <= ~Din;
                end
            end
        end
    end
endmodule
